// File: rtl/gray_operand_entry.sv
// Gray-coded multi-operand decimal entry: synchronises the switch bank and enter
// button, debounces the button and assembles NUM_OPERANDS BCD/binary operands.
module gray_operand_entry #(
  parameter int NUM_DIGITS      = 3,
  parameter int NUM_OPERANDS    = 2,
  parameter int BIN_W           = 14,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ag,
  input  logic                               bg,
  input  logic                               cg,
  input  logic                               dg,
  input  logic                               btn_enter,
  output logic [NUM_OPERANDS*NUM_DIGITS*4-1:0] op_bcd,
  output logic [NUM_OPERANDS*BIN_W-1:0]        op_bin,
  output logic [NUM_DIGITS*4-1:0]              live_bcd,
  output logic [1:0]                           op_idx,
  output logic [2:0]                           digit_cnt,
  output logic                                 digit_err,
  output logic                                 done
);

  localparam int DW = NUM_DIGITS * 4;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  // The state register doubles as the debug view of the FSM: done == (state == DONE).
  typedef enum logic {
    ENTRY = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t                       state;
  logic [3:0]                   gray_s1;
  logic [3:0]                   gray_s2;
  logic                         btn_s1;
  logic                         btn_s2;
  logic                         btn_level;
  logic [CW-1:0]                db_cnt;
  logic                         press;
  logic [3:0]                   digit;
  logic [NUM_OPERANDS*DW-1:0]   bcd_r;
  logic [NUM_OPERANDS*BIN_W-1:0] bin_r;
  logic [NUM_OPERANDS*DW-1:0]   bcd_next;
  logic [NUM_OPERANDS*BIN_W-1:0] bin_next;
  logic [DW-1:0]                cur_bcd;
  logic [BIN_W-1:0]             cur_bin;
  logic [DW-1:0]                new_bcd;
  logic [BIN_W+3:0]             new_bin_wide;
  logic                         last_digit;
  logic                         last_op;

  // Synchronisers and debouncer. press is a registered one-cycle pulse raised on
  // the edge where the debounced level goes 0->1; releases never raise it.
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_s1   <= '0;
      gray_s2   <= '0;
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      btn_level <= 1'b0;
      db_cnt    <= '0;
      press     <= 1'b0;
    end else begin
      gray_s1 <= {ag, bg, cg, dg};
      gray_s2 <= gray_s1;
      btn_s1  <= btn_enter;
      btn_s2  <= btn_s1;
      press   <= 1'b0;
      if (btn_s2 == btn_level) begin
        db_cnt <= '0;
      end else if (db_cnt == CW'(DEBOUNCE_CYCLES)) begin
        btn_level <= ~btn_level;
        db_cnt    <= '0;
        press     <= ~btn_level;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    digit[3] = gray_s2[3];
    digit[2] = digit[3] ^ gray_s2[2];
    digit[1] = digit[2] ^ gray_s2[1];
    digit[0] = digit[1] ^ gray_s2[0];
  end

  // Candidate operand images with the current digit folded into slice op_idx.
  always_comb begin
    cur_bcd = '0;
    cur_bin = '0;
    for (int k = 0; k < NUM_OPERANDS; k++) begin
      if (op_idx == 2'(k)) begin
        cur_bcd = bcd_r[k*DW +: DW];
        cur_bin = bin_r[k*BIN_W +: BIN_W];
      end
    end
    new_bcd      = (cur_bcd << 4) | DW'(digit);
    new_bin_wide = ({4'b0000, cur_bin} << 3) + ({4'b0000, cur_bin} << 1)
                 + {{BIN_W{1'b0}}, digit};
    bcd_next = bcd_r;
    bin_next = bin_r;
    for (int k = 0; k < NUM_OPERANDS; k++) begin
      if (op_idx == 2'(k)) begin
        bcd_next[k*DW +: DW]       = new_bcd;
        bin_next[k*BIN_W +: BIN_W] = new_bin_wide[BIN_W-1:0];
      end
    end
  end

  assign last_digit = (digit_cnt == 3'(NUM_DIGITS - 1));
  assign last_op    = (op_idx == 2'(NUM_OPERANDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ENTRY;
      bcd_r     <= '0;
      bin_r     <= '0;
      op_idx    <= '0;
      digit_cnt <= '0;
      digit_err <= 1'b0;
    end else begin
      digit_err <= 1'b0;
      if (press) begin
        case (state)
          ENTRY: begin
            if (digit > 4'd9) begin
              digit_err <= 1'b1;
            end else begin
              bcd_r <= bcd_next;
              bin_r <= bin_next;
              if (last_digit) begin
                digit_cnt <= '0;
                if (last_op) begin
                  state <= DONE;
                end else begin
                  op_idx <= op_idx + 2'd1;
                end
              end else begin
                digit_cnt <= digit_cnt + 3'd1;
              end
            end
          end
          DONE: begin
            // The press that leaves DONE only clears; it never counts as a digit.
            bcd_r     <= '0;
            bin_r     <= '0;
            op_idx    <= '0;
            digit_cnt <= '0;
            state     <= ENTRY;
          end
          default: state <= ENTRY;
        endcase
      end
    end
  end

  always_comb begin
    live_bcd = '0;
    for (int k = 0; k < NUM_OPERANDS; k++) begin
      if (op_idx == 2'(k)) live_bcd = bcd_r[k*DW +: DW];
    end
  end

  assign op_bcd = bcd_r;
  assign op_bin = bin_r;
  assign done   = (state == DONE);

endmodule
